// File: rtl/result_fifo_pkg.sv
// Shared sizing constants for the accelerator result path.
// The accelerator top level and result_fifo both take their widths from here.
package result_fifo_pkg;

  // Width of one accelerator result word (the wrData bus).
  localparam int RESULT_W   = 21;

  // Number of result words buffered; must be a power of two, at least 2.
  localparam int FIFO_DEPTH = 8;

  // Pointer width: indexes 0..FIFO_DEPTH-1 and wraps naturally.
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

  // Count width: one extra bit so the value FIFO_DEPTH is representable.
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

endpackage : result_fifo_pkg

// File: rtl/result_fifo_if.sv
// Bus bundle between the accelerator/consumer side and result_fifo.
//
// Handshake: strobe-based, not valid/ready. The producer asserts wrReq for
// each word it offers. The word is taken on that rising edge unless full is
// high and no read is taken in the same cycle; a refused word is dropped and
// recorded in overflow. The consumer asserts rdReq to pop. The pop is taken
// when empty is low, and rdData/rdValid follow on the next edge. A refused
// pop is recorded in underflow. clrErr clears both sticky flags.
interface result_fifo_if
  import result_fifo_pkg::*;
#(
  parameter int WIDTH = RESULT_W,
  parameter int DEPTH = FIFO_DEPTH
);

  logic                     wrReq;
  logic [WIDTH-1:0]         wrData;
  logic                     full;
  logic                     rdReq;
  logic [WIDTH-1:0]         rdData;
  logic                     rdValid;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;
  logic                     clrErr;

  // Producer/consumer side drives the strobes and observes status.
  modport master (
    output wrReq, wrData, rdReq, clrErr,
    input  full, rdData, rdValid, empty, count, overflow, underflow
  );

  // FIFO side accepts the strobes and drives status and read data.
  modport slave (
    input  wrReq, wrData, rdReq, clrErr,
    output full, rdData, rdValid, empty, count, overflow, underflow
  );

endinterface : result_fifo_if

// File: rtl/result_fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array for result_fifo.
// One synchronous write port and one combinational read port. The contents
// are deliberately not reset; a location is only read after it was written.
module fifo_mem #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the accepted word at the write address.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read port is combinational, so a same-cycle write to the same
  // location is not seen until the next cycle (read-before-write).
  assign rd_data_o = mem_q[rd_addr_i];

endmodule : fifo_mem

// File: rtl/result_fifo.sv
// result_fifo: buffers accelerator result words for a downstream consumer.
// Pointers, occupancy count, status flags, sticky error flags and the
// registered read-data stage live here; storage is the fifo_mem sub-module.
module result_fifo
  import result_fifo_pkg::*;
#(
  parameter int WIDTH = RESULT_W,
  parameter int DEPTH = FIFO_DEPTH   // power of two, at least 2
) (
  input  logic          clk,
  input  logic          rst,         // asynchronous, active-low
  result_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             full_q,   full_d;
  logic             empty_q,  empty_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_set;
  logic             unf_set;
  logic [WIDTH-1:0] mem_rd_data;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.wrData),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd_data)
  );

  // Accept decisions and next-state for pointers, count, flags and read data.
  always_comb begin
    rd_acc      = 1'b0;
    wr_acc      = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // A read never bypasses an empty FIFO, even with a same-cycle write.
    rd_acc = bus.rdReq && !empty_q;
    // When full, a write only fits if a read frees a slot in the same cycle.
    wr_acc = bus.wrReq && (!full_q || rd_acc);

    ovf_set = bus.wrReq && full_q && !rd_acc;
    unf_set = bus.rdReq && empty_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_rd_data;
    end
    rd_valid_d = rd_acc;

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Status is derived from the next count so it is registered alongside it.
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);

    // Sticky error flags: a new error event wins over a clear request.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (bus.clrErr) begin
      overflow_d = 1'b0;
    end
    if (unf_set) begin
      underflow_d = 1'b1;
    end else if (bus.clrErr) begin
      underflow_d = 1'b0;
    end
  end

  // State registers; reset empties the FIFO and clears all outputs at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.rdData    = rd_data_q;
  assign bus.rdValid   = rd_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule : result_fifo
